pwm_peripheral: RTL and testbench

Generates the 16 user output pins from the control registers written over SPI. Each pin is either forced low, driven static high, or driven by a shared 8-bit PWM waveform whose duty cycle comes from the duty-cycle register. It sits directly downstream of the SPI register file and drives the chip output pads.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_prescaler.sv | 32 +++
 rtl/pwm_peripheral.sv | 89 ++++++++
 tb/tb_pwm_peripheral.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output block.
package pwm_pkg;

    localparam int PWM_RES              = 8;
    localparam int PWM_PRESCALE_DEFAULT = 13;
    localparam int PWM_PINS             = 16;

    localparam logic [PWM_RES-1:0] DUTY_FULL = 8'hFF;

    typedef logic [PWM_PINS-1:0] pin_vec_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk by PRESCALE; tick_o pulses for one clk at the end of each count step.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_cnt_q;
    logic [CW-1:0] presc_cnt_d;

    // With PRESCALE=1 the counter sits at 0 and tick_o stays high.
    always_comb begin
        tick_o      = (presc_cnt_q == LAST);
        presc_cnt_d = tick_o ? '0 : presc_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output block: each pin forced low, static high, or the shared PWM waveform.
// Define PWM_SHADOW_EN to latch the duty cycle only at the period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [PWM_RES-1:0]  pwm_duty_cycle,
    output logic [PWM_PINS-1:0] out
);

    logic               tick;
    logic [PWM_RES-1:0] pwm_cnt_q;
    logic [PWM_RES-1:0] pwm_cnt_d;
    logic [PWM_RES-1:0] duty_eff;
    logic               pwm_sig;
    pin_vec_t           en_out;
    pin_vec_t           en_pwm;
    pin_vec_t           out_q;
    pin_vec_t           out_d;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // 8-bit add wraps 255 -> 0 naturally.
    always_comb begin
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [PWM_RES-1:0] duty_q;
    logic [PWM_RES-1:0] duty_d;

    // Load only as pwm_cnt wraps so every period uses one duty value.
    always_comb begin
        duty_d = (tick && (pwm_cnt_q == 8'hFF)) ? pwm_duty_cycle : duty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // Full-scale duty is forced high so 0xFF has no one-step gap.
    always_comb begin
        pwm_sig = (duty_eff == DUTY_FULL) | (pwm_cnt_q < duty_eff);
        en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_d   = en_out & (~en_pwm | {PWM_PINS{pwm_sig}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: PRESCALE=1 and PRESCALE=13 instances share inputs.
module tb_pwm_peripheral;

  import pwm_pkg::*;

`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out1;
  logic [15:0] out13;

  pwm_peripheral #(.PRESCALE(1)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out1)
  );

  pwm_peripheral #(.PRESCALE(13)) u_dut13 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out13)
  );

  // ---------------- reference model ----------------
  // Count position is derived from the number of clk edges since reset:
  // the count seen by edge n is (n / P) mod 256.
  int          n_edges;
  logic [7:0]  sh1;
  logic [7:0]  sh13;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] model_out(input int p, input int n, input logic [7:0] d,
                                            input logic [15:0] eo, input logic [15:0] ep);
    int   cnt;
    logic sig;
    cnt = (n / p) % 256;
    sig = (d == 8'hFF) || (cnt < int'(d));
    return eo & (~ep | {16{sig}});
  endfunction

  always @(posedge clk) begin
    logic [7:0] d1;
    logic [7:0] d13;
    if (!rst_n) begin
      n_edges = 0;
      sh1     = 8'h00;
      sh13    = 8'h00;
      exp_q.push_back(32'h0);
    end else begin
      d1  = SHADOW ? sh1  : duty;
      d13 = SHADOW ? sh13 : duty;
      exp_q.push_back({model_out(13, n_edges, d13, en_out, en_pwm),
                       model_out(1,  n_edges, d1,  en_out, en_pwm)});
      if ((n_edges % 256) == 255) sh1 = duty;
      if ((n_edges % 13) == 12 && ((n_edges / 13) % 256) == 255) sh13 = duty;
      n_edges = n_edges + 1;
    end
  end

  // ---------------- counters ----------------
  int checks;
  int errors;

  // ---------------- driver: advance one cycle and score both instances ----------------
  task automatic clk_wait();
    logic [31:0] e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out1 !== e[15:0]) begin
        errors++;
        $display("FAIL sb_out_p1 t=%0t got %h exp %h", $time, out1, e[15:0]);
      end
      checks++;
      if (out13 !== e[31:16]) begin
        errors++;
        $display("FAIL sb_out_p13 t=%0t got %h exp %h", $time, out13, e[31:16]);
      end
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) clk_wait();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [15:0] exp_first;
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    run(3);
    checks++;
    if (out1 !== 16'h0000 || out13 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold got %h/%h exp 0000", out1, out13);
    end
    rst_n = 1'b1;
    run(2);
    exp_first = SHADOW ? 16'h0000 : 16'hFFFF;
    checks++;
    if (out1 !== exp_first || out13 !== exp_first) begin
      errors++;
      $display("FAIL reset_release got %h/%h exp %h", out1, out13, exp_first);
    end
  endtask

  task automatic test_static();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    run(2);
    checks++;
    if (out1 !== 16'hFFFF || out13 !== 16'hFFFF) begin
      errors++;
      $display("FAIL static_all got %h/%h exp ffff", out1, out13);
    end
    en_out = 16'h00FF;
    clk_wait();
    checks++;
    if (out1 !== 16'h00FF || out13 !== 16'h00FF) begin
      errors++;
      $display("FAIL static_one_clk got %h/%h exp 00ff", out1, out13);
    end
  endtask

  task automatic test_duty(input logic [7:0] d, input int periods);
    int   highs;
    int   rises;
    int   exp_highs;
    int   exp_rises;
    logic prev;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = d;
    run(512);
    highs = 0;
    rises = 0;
    prev  = out1[0];
    for (int i = 0; i < 256 * periods; i++) begin
      clk_wait();
      if (out1[0]) highs++;
      if (out1[0] && !prev) rises++;
      prev = out1[0];
    end
    exp_highs = (d == 8'hFF) ? 256 * periods : int'(d) * periods;
    exp_rises = (d == 8'h00 || d == 8'hFF) ? 0 : periods;
    checks++;
    if (highs != exp_highs) begin
      errors++;
      $display("FAIL duty_high_time d=%h got %0d exp %0d", d, highs, exp_highs);
    end
    checks++;
    if (rises != exp_rises) begin
      errors++;
      $display("FAIL duty_rises d=%h got %0d exp %0d", d, rises, exp_rises);
    end
  endtask

  task automatic test_prescale13();
    int   highs;
    int   rises;
    logic prev;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h40;
    run(2 * 3328);
    highs = 0;
    rises = 0;
    prev  = out13[5];
    for (int i = 0; i < 3328; i++) begin
      clk_wait();
      if (out13[5]) highs++;
      if (out13[5] && !prev) rises++;
      prev = out13[5];
    end
    checks++;
    if (highs != 832) begin
      errors++;
      $display("FAIL p13_high_time got %0d exp 832", highs);
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL p13_rises got %0d exp 1", rises);
    end
  endtask

  task automatic test_mixed();
    int toggles;
    bit hi_ok;
    bit lo_ok;
    logic prev;
    en_out = 16'hF0F0;
    en_pwm = 16'hFF00;
    duty   = 8'h20;
    run(512);
    toggles = 0;
    hi_ok   = 1'b1;
    lo_ok   = 1'b1;
    prev    = out1[13];
    for (int i = 0; i < 256; i++) begin
      clk_wait();
      if (out1[15:12] != 4'h0 && out1[15:12] != 4'hF) hi_ok = 1'b0;
      if (out1[13] != prev) toggles++;
      prev = out1[13];
      if (out1[7:4] !== 4'hF) hi_ok = 1'b0;
      if (out1[11:8] !== 4'h0 || out1[3:0] !== 4'h0) lo_ok = 1'b0;
    end
    checks++;
    if (toggles != 2) begin
      errors++;
      $display("FAIL mixed_toggles got %0d exp 2", toggles);
    end
    checks++;
    if (!hi_ok) begin
      errors++;
      $display("FAIL mixed_static_high got 0 exp 1");
    end
    checks++;
    if (!lo_ok) begin
      errors++;
      $display("FAIL mixed_forced_low got 0 exp 1");
    end
  endtask

  task automatic test_duty_change();
    int i;
    int highs;
    logic exp_bit;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h10;
    run(512);
    i = 0;
    while ((n_edges % 256) != 100 && i < 300) begin
      clk_wait();
      i++;
    end
    checks++;
    if ((n_edges % 256) != 100) begin
      errors++;
      $display("FAIL change_sync got %0d exp 100", n_edges % 256);
    end
    duty = 8'hC0;
    clk_wait();
    exp_bit = SHADOW ? 1'b0 : 1'b1;
    checks++;
    if (out1[0] !== exp_bit) begin
      errors++;
      $display("FAIL change_next_clk got %b exp %b", out1[0], exp_bit);
    end
    i = 0;
    while ((n_edges % 256) != 0 && i < 300) begin
      clk_wait();
      i++;
    end
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      clk_wait();
      if (out1[0]) highs++;
    end
    checks++;
    if (highs != 192) begin
      errors++;
      $display("FAIL change_next_period got %0d exp 192", highs);
    end
  endtask

  task automatic test_async_reset();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    run(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out1 !== 16'h0000 || out13 !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got %h/%h exp 0000", out1, out13);
    end
    run(2);
    rst_n = 1'b1;
    en_pwm = 16'hFFFF;
    duty   = 8'h55;
    run(300);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) en_out = 16'($urandom);
      if ($urandom_range(0, 7) == 0) en_pwm = 16'($urandom);
      clk_wait();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en_out = 16'h0000;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    test_reset();
    test_static();
    test_duty(8'h80, 1);
    test_duty(8'h00, 1);
    test_duty(8'hFF, 3);
    for (int i = 0; i < 3; i++) test_duty(8'($urandom_range(1, 254)), 1);
    test_prescale13();
    test_mixed();
    test_duty_change();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
